// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and helpers for the 7-segment scan display path.
//   SEG_0..SEG_9, SEG_BLANK : segment patterns, bit order {g,f,e,d,c,b,a}, active high
//   bcd_to_seg()            : BCD digit to segment pattern; codes 10..15 decode to blank
//   state_e                 : scanner FSM states
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [0:0] {
    IDLE,
    SCAN
  } state_e;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD to 7-segment decoder with a blank override.
//   digit : BCD code of the digit to show
//   blank : forces the pattern dark (leading-zero suppression)
//   seg   : {g,f,e,d,c,b,a}, active high
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : bcd_to_seg(digit);

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: multiplexed N-digit 7-segment driver.
// Scans a BCD snapshot one digit per SCAN_DIV-cycle slot, with DEAD all-off cycles at the
// start of each slot, optional leading-zero suppression and a frame-rate blink.
//   CLK, RST_N  : clock, asynchronous active-low reset
//   EN          : enable; low forces idle and dark
//   BLINK       : blink the display at the BLINK_DIV frame rate
//   digits_in   : packed BCD, digit 0 in [3:0]
//   dp_in       : decimal point per digit
//   segments    : {g,f,e,d,c,b,a} of the selected digit, registered
//   dp          : decimal point of the selected digit, registered
//   digit_sel   : one-hot digit enable or all-off, registered
//   frame_tick  : pulse on the last cycle of each frame, registered
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned DEAD        = 2,
  parameter int unsigned BLINK_DIV   = 250,
  parameter bit          LZ_SUPPRESS = 1'b1,
  parameter bit          ACTIVE_LOW  = 1'b0
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic                      BLINK,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic [6:0]                segments,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      frame_tick
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [BLK_W-1:0]          blink_cnt_q, blink_cnt_d;
  logic                      blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0]   snap_digits_q;
  logic [NUM_DIGITS-1:0]     snap_dp_q;
  logic                      snap_load;

  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [NUM_DIGITS-1:0]     sel_q, sel_d;
  logic                      tick_q, tick_d;

  logic                      slot_end, frame_end;
  logic [3:0]                cur_digit;
  logic                      cur_dp;
  logic [NUM_DIGITS-1:0]     lz_mask;
  logic                      zero_above;
  logic                      lz_blank;
  logic [6:0]                dec_seg;
  logic                      dark;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  // State register, counters and snapshot.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      if (snap_load) begin
        snap_digits_q <= digits_in;
        snap_dp_q     <= dp_in;
      end
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d       = EN ? SCAN : IDLE;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    snap_load     = 1'b0;
    if (!EN) begin
      cnt_d         = '0;
      idx_d         = '0;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: snap_load = 1'b1;
        SCAN: begin
          cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
          if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end
          // Frame boundary: refresh the snapshot so a frame never mixes old and new data.
          if (frame_end) begin
            snap_load   = 1'b1;
            blink_cnt_d = (blink_cnt_q == BLK_LAST) ? '0 : blink_cnt_q + BLK_W'(1);
            if (blink_cnt_q == BLK_LAST) blink_phase_d = ~blink_phase_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Leading-zero mask: digit i is blank when it and every higher digit are zero.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (snap_digits_q[4*i +: 4] == 4'd0);
      lz_mask[i] = zero_above;
    end
  end

  assign cur_digit = snap_digits_q[{idx_q, 2'b00} +: 4];
  assign cur_dp    = snap_dp_q[idx_q];
  assign lz_blank  = LZ_SUPPRESS && lz_mask[idx_q];

  seg7_decode u_decode (
    .digit (cur_digit),
    .blank (lz_blank),
    .seg   (dec_seg)
  );

  // Output next-state: all outputs are one cycle behind cnt/idx.
  always_comb begin
    dark   = BLINK && blink_phase_q;
    seg_d  = '0;
    dp_d   = 1'b0;
    sel_d  = '0;
    tick_d = 1'b0;
    if (state_q == SCAN) begin
      tick_d = frame_end;
      if (!dark) begin
        seg_d = dec_seg;
        dp_d  = cur_dp;
        if (!(cnt_q < CNT_DEAD)) sel_d = NUM_DIGITS'(1) << idx_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_q  <= '0;
      dp_q   <= 1'b0;
      sel_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      sel_q  <= sel_d;
      tick_q <= tick_d;
    end
  end

  assign segments   = seg_q ^ {7{ACTIVE_LOW}};
  assign dp         = dp_q ^ ACTIVE_LOW;
  assign digit_sel  = sel_q ^ {NUM_DIGITS{ACTIVE_LOW}};
  assign frame_tick = tick_q ^ ACTIVE_LOW;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display: an active-high and an active-low instance share
// stimulus and are compared every cycle against a position-based reference model.
module tb_seg7_scan_display;

  localparam int N = 4;
  localparam int S = 8;
  localparam int D = 2;
  localparam int B = 2;
  localparam int F = N * S;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EN;
  logic        BLINK;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;

  logic [6:0] seg_h, seg_l;
  logic       dp_h, dp_l;
  logic [3:0] sel_h, sel_l;
  logic       tick_h, tick_l;

  int vectors = 0;
  int errors  = 0;

  // Reference model: scan position counted in cycles since the scan started.
  bit          m_on  = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_snap = '0;
  logic [3:0]  m_dp   = '0;

  always #5 CLK = ~CLK;

  seg7_scan_display #(
    .NUM_DIGITS (N), .SCAN_DIV (S), .DEAD (D), .BLINK_DIV (B),
    .LZ_SUPPRESS(1'b1), .ACTIVE_LOW (1'b0)
  ) u_dut_h (
    .CLK (CLK), .RST_N (RST_N), .EN (EN), .BLINK (BLINK),
    .digits_in (digits_in), .dp_in (dp_in),
    .segments (seg_h), .dp (dp_h), .digit_sel (sel_h), .frame_tick (tick_h)
  );

  seg7_scan_display #(
    .NUM_DIGITS (N), .SCAN_DIV (S), .DEAD (D), .BLINK_DIV (B),
    .LZ_SUPPRESS(1'b1), .ACTIVE_LOW (1'b1)
  ) u_dut_l (
    .CLK (CLK), .RST_N (RST_N), .EN (EN), .BLINK (BLINK),
    .digits_in (digits_in), .dp_in (dp_in),
    .segments (seg_l), .dp (dp_l), .digit_sel (sel_l), .frame_tick (tick_l)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic check_outputs(input logic [6:0] e_seg, input logic e_dp, input logic [3:0] e_sel,
                               input logic e_tick, input string tag);
    vectors++;
    assert (seg_h === e_seg) else begin
      errors++; $error("FAIL %s seg: got %b want %b (pos %0d)", tag, seg_h, e_seg, m_pos);
    end
    assert (dp_h === e_dp) else begin
      errors++; $error("FAIL %s dp: got %b want %b (pos %0d)", tag, dp_h, e_dp, m_pos);
    end
    assert (sel_h === e_sel) else begin
      errors++; $error("FAIL %s sel: got %b want %b (pos %0d)", tag, sel_h, e_sel, m_pos);
    end
    assert (tick_h === e_tick) else begin
      errors++; $error("FAIL %s tick: got %b want %b (pos %0d)", tag, tick_h, e_tick, m_pos);
    end
    assert (seg_l === ~e_seg) else begin
      errors++; $error("FAIL %s seg_n: got %b want %b (pos %0d)", tag, seg_l, ~e_seg, m_pos);
    end
    assert (dp_l === ~e_dp) else begin
      errors++; $error("FAIL %s dp_n: got %b want %b (pos %0d)", tag, dp_l, ~e_dp, m_pos);
    end
    assert (sel_l === ~e_sel) else begin
      errors++; $error("FAIL %s sel_n: got %b want %b (pos %0d)", tag, sel_l, ~e_sel, m_pos);
    end
    assert (tick_l === ~e_tick) else begin
      errors++; $error("FAIL %s tick_n: got %b want %b (pos %0d)", tag, tick_l, ~e_tick, m_pos);
    end
  endtask

  // One clock: predict from the pre-edge model, advance the model, check after the edge.
  task automatic tick(input string tag);
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_sel;
    logic       e_tick;
    int         cnt, idx, frame;
    bit         dark;
    e_seg = '0; e_dp = 1'b0; e_sel = '0; e_tick = 1'b0;
    if (m_on && RST_N) begin
      cnt    = m_pos % S;
      idx    = (m_pos / S) % N;
      frame  = m_pos / F;
      dark   = BLINK && ((frame / B) % 2 == 1);
      e_tick = (m_pos % F == F - 1);
      if (!dark) begin
        if (idx != 0 && (m_snap >> (4 * idx)) == 16'd0) e_seg = '0;
        else e_seg = ref_seg(m_snap[4*idx +: 4]);
        e_dp = m_dp[idx];
        if (cnt >= D) e_sel = 4'(1 << idx);
      end
    end
    if (!RST_N || !EN) begin
      m_on = 1'b0; m_pos = 0;
    end else if (!m_on) begin
      m_on = 1'b1; m_pos = 0; m_snap = digits_in; m_dp = dp_in;
    end else begin
      m_pos++;
      if (m_pos % F == 0) begin
        m_snap = digits_in; m_dp = dp_in;
      end
    end
    @(posedge CLK);
    #1;
    check_outputs(e_seg, e_dp, e_sel, e_tick, tag);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; BLINK = 1'b0; digits_in = 16'h1234; dp_in = 4'b0000;
    run(3, "reset");
    RST_N = 1'b1;
    run(100, "idle");

    EN = 1'b1;
    run(70, "scan_1234");

    // Change mid-frame: the old value must finish its frame.
    run(5, "pre_tear");
    digits_in = 16'h0050;
    run(64, "lz_0050");
    digits_in = 16'h0000;
    run(64, "lz_0000");
    digits_in = 16'h12A4;
    run(40, "code_a");

    // EN drop mid-slot, then restart.
    run(3, "pre_en_drop");
    EN = 1'b0;
    run(4, "en_drop");
    EN = 1'b1; digits_in = 16'h9876; dp_in = 4'b0100; BLINK = 1'b1;
    run(300, "blink");
    BLINK = 1'b0;
    run(45, "blink_off");
    BLINK = 1'b1;
    run(100, "blink_resume");

    // Reset asserted mid-scan: outputs must go inactive without a clock edge.
    tick("pre_rst");
    #2 RST_N = 1'b0;
    #1;
    m_on = 1'b0; m_pos = 0;
    check_outputs('0, 1'b0, '0, 1'b0, "async_rst");
    run(2, "rst_held");
    RST_N = 1'b1;
    BLINK = 1'b0;
    run(40, "post_rst");

    // Random stimulus.
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: digits_in = 16'($urandom) & 16'h000F;
          1: digits_in = 16'($urandom) & 16'h00FF;
          2: digits_in = 16'($urandom) & 16'h0FFF;
          default: digits_in = 16'($urandom);
        endcase
        dp_in = 4'($urandom);
      end
      if (EN && $urandom_range(0, 149) == 0) EN = 1'b0;
      else if (!EN && $urandom_range(0, 3) == 0) EN = 1'b1;
      if ($urandom_range(0, 79) == 0) BLINK = ~BLINK;
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
